// File: rtl/filter_pkg.sv
// filter_pkg
//   Shared definitions for the programmable trapezoidal shaping filter:
//   default widths and runtime configuration, the signed accumulator type,
//   the configuration record {k, l, m, shift} and the output clamp helper.
//   No ports (package).
package filter_pkg;

    localparam int ADC_W     = 12;
    localparam int OUT_W     = 16;
    localparam int ACC_W     = 32;
    localparam int DEPTH     = 64;
    localparam int CFG_KW    = $clog2(DEPTH) + 1;
    localparam int CFG_MW    = 10;
    localparam int CFG_SW    = 5;

    localparam int DEF_K     = 4;
    localparam int DEF_L     = 8;
    localparam int DEF_M     = 0;
    localparam int DEF_SHIFT = 4;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] out_t;

    typedef struct packed {
        logic [CFG_KW-1:0] k;
        logic [CFG_KW-1:0] l;
        logic [CFG_MW-1:0] m;
        logic [CFG_SW-1:0] shift;
    } cfg_t;

    typedef struct packed {
        logic clamped;
        out_t value;
    } sat_t;

    // Clamp a wide signed value into the output range. The value fits when
    // all bits from the output sign bit upward are identical.
    function automatic sat_t saturate(input acc_t x);
        sat_t                 res;
        logic [ACC_W-OUT_W:0] upper;
        upper       = x[ACC_W-1:OUT_W-1];
        res.clamped = !((&upper) || !(|upper));
        if (!res.clamped) begin
            res.value = x[OUT_W-1:0];
        end else if (x[ACC_W-1]) begin
            res.value = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res.value = {1'b0, {(OUT_W-1){1'b1}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/tap_delay_line.sv
// tap_delay_line
//   DEPTH-entry shift register of raw ADC samples with runtime taps.
//   line_q[0] holds the previous accepted sample v(n-1), so the tap for
//   delay j reads entry j-1.
//   Ports:
//     clk_i      clock
//     rst_i      asynchronous active-high reset, clears the line
//     clear_i    synchronous clear of the whole line
//     shift_i    push sample_i into the line
//     sample_i   sample entering the line
//     k_i, l_i   tap delays (1..DEPTH, k_i + l_i <= DEPTH)
//     tap_k_o    v(n-K)
//     tap_l_o    v(n-L)
//     tap_kl_o   v(n-K-L)
module tap_delay_line #(
    parameter int ADC_W = 12,
    parameter int DEPTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       shift_i,
    input  logic [ADC_W-1:0]           sample_i,
    input  logic [$clog2(DEPTH):0]     k_i,
    input  logic [$clog2(DEPTH):0]     l_i,
    output logic [ADC_W-1:0]           tap_k_o,
    output logic [ADC_W-1:0]           tap_l_o,
    output logic [ADC_W-1:0]           tap_kl_o
);
    import filter_pkg::*;

    localparam int TAP_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [ADC_W-1:0] line_q [DEPTH];
    logic [IDX_W-1:0] idx_k;
    logic [IDX_W-1:0] idx_l;
    logic [IDX_W-1:0] idx_kl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else if (shift_i) begin
            line_q[0] <= sample_i;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    // Delays are at least 1 and their sum never exceeds DEPTH, so the
    // decremented values always fit the index width.
    assign idx_k  = IDX_W'(k_i - TAP_W'(1));
    assign idx_l  = IDX_W'(l_i - TAP_W'(1));
    assign idx_kl = IDX_W'(k_i + l_i - TAP_W'(1));

    assign tap_k_o  = line_q[idx_k];
    assign tap_l_o  = line_q[idx_l];
    assign tap_kl_o = line_q[idx_kl];

endmodule

// File: rtl/trap_filter_prog.sv
// trap_filter_prog
//   Runtime-programmable trapezoidal shaping filter for one ADC stream.
//   Four valid-tagged stages: d (difference), p (first accumulator),
//   s (pole-zero corrected second accumulator), clamped output register.
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     in_data, in_valid     unsigned ADC sample and its qualifier
//     cfg_load              strobe requesting cfg_k/l/m/shift to be loaded
//     cfg_k, cfg_l          rise time K and rise+flat time L
//     cfg_m, cfg_shift      pole-zero multiplier and output right shift
//     cfg_err               one-cycle pulse on a rejected configuration
//     sat_flag              sticky: an emitted output was clamped
//     out_data, out_valid   signed filtered sample and its qualifier
module trap_filter_prog #(
    parameter int ADC_W     = filter_pkg::ADC_W,
    parameter int OUT_W     = filter_pkg::OUT_W,
    parameter int ACC_W     = filter_pkg::ACC_W,
    parameter int DEPTH     = filter_pkg::DEPTH,
    parameter int DEF_K     = filter_pkg::DEF_K,
    parameter int DEF_L     = filter_pkg::DEF_L,
    parameter int DEF_M     = filter_pkg::DEF_M,
    parameter int DEF_SHIFT = filter_pkg::DEF_SHIFT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADC_W-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   cfg_load,
    input  logic [$clog2(DEPTH):0] cfg_k,
    input  logic [$clog2(DEPTH):0] cfg_l,
    input  logic [9:0]             cfg_m,
    input  logic [4:0]             cfg_shift,
    output logic                   cfg_err,
    output logic                   sat_flag,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid
);
    import filter_pkg::*;

    localparam int KW = $clog2(DEPTH) + 1;

    localparam cfg_t DEF_CFG = '{
        k:     CFG_KW'(DEF_K),
        l:     CFG_KW'(DEF_L),
        m:     CFG_MW'(DEF_M),
        shift: CFG_SW'(DEF_SHIFT)
    };

    function automatic logic signed [ACC_W-1:0] zext(input logic [ADC_W-1:0] x);
        return $signed({{(ACC_W-ADC_W){1'b0}}, x});
    endfunction

    cfg_t                    cfg_q;
    cfg_t                    cfg_req;
    logic [KW:0]             req_sum;
    logic                    cfg_ok;
    logic                    cfg_acc;
    logic                    cfg_rej;
    logic                    shift_en;

    logic [KW-1:0]           warm_q;
    logic [KW-1:0]           kl_act;
    logic                    warm_done;

    logic [ADC_W-1:0]        tap_k;
    logic [ADC_W-1:0]        tap_l;
    logic [ADC_W-1:0]        tap_kl;

    logic signed [ACC_W-1:0] d_p0;
    logic signed [ACC_W-1:0] d_p1_q;
    logic                    smp_p1_q;
    logic                    vld_p1_q;
    logic signed [ACC_W-1:0] p_p2_q;
    logic signed [ACC_W-1:0] d_p2_q;
    logic                    smp_p2_q;
    logic                    vld_p2_q;
    logic signed [ACC_W-1:0] m_ext;
    logic signed [ACC_W-1:0] r_p2;
    logic signed [ACC_W-1:0] s_p3_q;
    logic                    vld_p3_q;
    logic signed [ACC_W-1:0] s_shr;
    sat_t                    sat_p3;

    // Configuration request check. The sum is one bit wider so that
    // oversized K+L cannot wrap into range.
    assign cfg_req  = '{k: cfg_k, l: cfg_l, m: cfg_m, shift: cfg_shift};
    assign req_sum  = {1'b0, cfg_k} + {1'b0, cfg_l};
    assign cfg_ok   = (cfg_k != '0) && (cfg_k <= cfg_l) && (req_sum <= (KW+1)'(DEPTH));
    assign cfg_acc  = cfg_load && cfg_ok;
    assign cfg_rej  = cfg_load && !cfg_ok;
    // A sample coinciding with an accepted load belongs to neither config.
    assign shift_en = in_valid && !cfg_acc;

    assign kl_act    = cfg_q.k + cfg_q.l;
    assign warm_done = (warm_q >= kl_act);

    tap_delay_line #(
        .ADC_W (ADC_W),
        .DEPTH (DEPTH)
    ) u_line (
        .clk_i    (clk),
        .rst_i    (reset),
        .clear_i  (cfg_acc),
        .shift_i  (shift_en),
        .sample_i (in_data),
        .k_i      (cfg_q.k),
        .l_i      (cfg_q.l),
        .tap_k_o  (tap_k),
        .tap_l_o  (tap_l),
        .tap_kl_o (tap_kl)
    );

    assign d_p0   = zext(in_data) - zext(tap_k) - zext(tap_l) + zext(tap_kl);
    assign m_ext  = $signed({{(ACC_W-CFG_MW){1'b0}}, cfg_q.m});
    assign r_p2   = p_p2_q + m_ext * d_p2_q;
    assign s_shr  = s_p3_q >>> cfg_q.shift;
    assign sat_p3 = saturate(s_shr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q     <= DEF_CFG;
            warm_q    <= '0;
            d_p1_q    <= '0;
            smp_p1_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            p_p2_q    <= '0;
            d_p2_q    <= '0;
            smp_p2_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            s_p3_q    <= '0;
            vld_p3_q  <= 1'b0;
            cfg_err   <= 1'b0;
            sat_flag  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            cfg_err <= cfg_rej;
            if (cfg_acc) begin
                // New configuration: flush history, accumulators and tags.
                cfg_q     <= cfg_req;
                warm_q    <= '0;
                smp_p1_q  <= 1'b0;
                vld_p1_q  <= 1'b0;
                p_p2_q    <= '0;
                smp_p2_q  <= 1'b0;
                vld_p2_q  <= 1'b0;
                s_p3_q    <= '0;
                vld_p3_q  <= 1'b0;
                out_valid <= 1'b0;
                sat_flag  <= 1'b0;
            end else begin
                // Stage 1: difference d(n)
                smp_p1_q <= in_valid;
                vld_p1_q <= in_valid && warm_done;
                if (in_valid) begin
                    d_p1_q <= d_p0;
                    if (!warm_done) warm_q <= warm_q + KW'(1);
                end
                // Stage 2: p(n) = p(n-1) + d(n)
                smp_p2_q <= smp_p1_q;
                vld_p2_q <= vld_p1_q;
                if (smp_p1_q) begin
                    p_p2_q <= p_p2_q + d_p1_q;
                    d_p2_q <= d_p1_q;
                end
                // Stage 3: s(n) = s(n-1) + p(n) + M*d(n)
                vld_p3_q <= vld_p2_q;
                if (smp_p2_q) s_p3_q <= s_p3_q + r_p2;
                // Stage 4: shifted, clamped output
                out_valid <= vld_p3_q;
                if (vld_p3_q) begin
                    out_data <= sat_p3.value;
                    if (sat_p3.clamped) sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trap_filter_prog.sv
module tb_trap_filter_prog;

    localparam int ADC_W = 12;
    localparam int OUT_W = 16;
    localparam int DEPTH = 64;
    localparam int KW    = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADC_W-1:0]  in_data;
    logic              in_valid;
    logic              cfg_load;
    logic [KW-1:0]     cfg_k;
    logic [KW-1:0]     cfg_l;
    logic [9:0]        cfg_m;
    logic [4:0]        cfg_shift;
    logic              cfg_err;
    logic              sat_flag;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;

    trap_filter_prog dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .cfg_load  (cfg_load),
        .cfg_k     (cfg_k),
        .cfg_l     (cfg_l),
        .cfg_m     (cfg_m),
        .cfg_shift (cfg_shift),
        .cfg_err   (cfg_err),
        .sat_flag  (sat_flag),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int val;
        int sat;
    } exp_t;

    exp_t sb[$];

    int mk, ml, mm, msh;
    int hist[$];
    int mp, ms, nacc, msticky;

    function automatic int past(input int j);
        return (j < hist.size()) ? hist[j] : 0;
    endfunction

    task automatic model_clear();
        hist.delete();
        mp = 0; ms = 0; nacc = 0; msticky = 0;
    endtask

    task automatic model_defaults();
        mk = 4; ml = 8; mm = 0; msh = 4;
        model_clear();
    endtask

    // One accepted sample: trapezoid difference, two running sums, then
    // shift and clamp into the 16-bit signed range.
    task automatic model_step(input int v);
        int d, o, clamped;
        exp_t e;
        hist.push_front(v);
        if (hist.size() > DEPTH + 1) void'(hist.pop_back());
        d  = past(0) - past(mk) - past(ml) + past(mk + ml);
        mp = mp + d;
        ms = ms + mp + mm * d;
        o  = ms >>> msh;
        clamped = 0;
        if (o > 32767)  begin o = 32767;  clamped = 1; end
        if (o < -32768) begin o = -32768; clamped = 1; end
        nacc++;
        if (nacc > mk + ml) begin
            if (clamped) msticky = 1;
            e.due = cyc + 4;
            e.val = o;
            e.sat = msticky;
            sb.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int exp_v;
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            check("out_valid_missing", 0, 1);
            void'(sb.pop_front());
        end
        exp_v = (sb.size() > 0 && sb[0].due == cyc) ? 1 : 0;
        if (out_valid || exp_v != 0) begin
            check("out_valid", int'(out_valid), exp_v);
            if (exp_v != 0) begin
                e = sb.pop_front();
                if (out_valid) begin
                    check("out_data", int'($signed(out_data)), e.val);
                    check("sat_flag", int'(sat_flag), e.sat);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int v);
        in_data  = ADC_W'(v);
        in_valid = 1'b1;
        model_step(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_cfg(input int k, input int l, input int m, input int sh,
                            input bit with_smp, input int v);
        bit ok;
        ok = (k >= 1) && (k <= l) && (k + l <= DEPTH);
        cfg_k     = KW'(k);
        cfg_l     = KW'(l);
        cfg_m     = 10'(m);
        cfg_shift = 5'(sh);
        cfg_load  = 1'b1;
        if (with_smp) begin
            in_data  = ADC_W'(v);
            in_valid = 1'b1;
        end
        if (ok) begin
            mk = k; ml = l; mm = m; msh = sh;
            model_clear();
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        end else if (with_smp) begin
            model_step(v);
        end
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        check("cfg_err_pulse", int'(cfg_err), ok ? 0 : 1);
        if (ok) check("sat_flag_cleared", int'(sat_flag), 0);
        tick();
        check("cfg_err_one_cycle", int'(cfg_err), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        cfg_k     = '0;
        cfg_l     = '0;
        cfg_m     = '0;
        cfg_shift = '0;
        model_defaults();
        tick();
        tick();
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data",  int'(out_data),  0);
        check("reset_sat_flag",  int'(sat_flag),  0);
        check("reset_cfg_err",   int'(cfg_err),   0);
        reset = 1'b0;
        tick();

        // Step response, back-to-back samples
        load_cfg(2, 4, 0, 0, 1'b0, 0);
        for (int i = 0; i < 6; i++) send(0);
        for (int i = 0; i < 14; i++) send(10);
        idle(6);

        // Same step, one sample every third cycle
        load_cfg(2, 4, 0, 0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin send(0); idle(2); end
        for (int i = 0; i < 14; i++) begin send(10); idle(2); end
        idle(6);

        // Random data, random gaps, random pole-zero factor and shift
        load_cfg(3, 5, int'($urandom_range(0, 1023)), int'($urandom_range(4, 12)), 1'b0, 0);
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, 4095)));
            idle(int'($urandom_range(0, 2)));
        end
        idle(6);

        // Saturation on a full-scale step
        load_cfg(4, 8, 0, 0, 1'b0, 0);
        for (int i = 0; i < 30; i++) send(4095);
        check("sat_flag_set", int'(sat_flag), 1);

        // Rejected configuration with a coincident sample: stream continues
        load_cfg(5, 3, 0, 0, 1'b1, 4095);
        check("sat_flag_sticky", int'(sat_flag), msticky);
        for (int i = 0; i < 6; i++) send(4095);
        load_cfg(40, 40, 0, 0, 1'b1, 4095);
        for (int i = 0; i < 4; i++) send(4095);

        // Accepted configuration mid-stream, coincident sample dropped
        send(4095);
        load_cfg(3, 6, 5, 3, 1'b1, 4095);
        for (int i = 0; i < 30; i++) begin
            send(int'($urandom_range(0, 4095)));
            if (($urandom & 3) == 0) idle(1);
        end

        // Reset while the pipeline is full
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 4095)));
        reset = 1'b1;
        while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_out_data",  int'(out_data),  0);
        check("midreset_sat_flag",  int'(sat_flag),  0);
        tick();
        tick();
        reset = 1'b0;
        model_defaults();
        tick();
        for (int i = 0; i < 25; i++) send(int'($urandom_range(0, 4095)));
        idle(8);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/trap_filter_prog.md
Name: trap_filter_prog

Overview:
- Next-generation trapezoidal shaping filter for the ADC data path, for a single ADC channel stream.
- Timing constants K, L, pole-zero factor M and output shift are runtime-programmable instead of fixed at build time.
- Adds an input valid qualifier, warm-up suppression, output saturation and configuration error checking.
- Sits between the ADC sample register and the peak/energy logic.

Parameters:
- ADC_W, 12, width of unsigned ADC input sample.
- OUT_W, 16, width of signed filtered output.
- ACC_W, 32, width of internal signed arithmetic and accumulators.
- DEPTH, 64, delay-line length; K+L must not exceed DEPTH.
- DEF_K / DEF_L / DEF_M / DEF_SHIFT, 4 / 8 / 0 / 4, configuration after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  ADC_W  unsigned ADC sample.
- in_valid  in  1  in_data is a new sample this cycle.
- cfg_load  in  1  one-cycle strobe: request to load cfg_* fields.
- cfg_k  in  $clog2(DEPTH)+1  rise time K.
- cfg_l  in  $clog2(DEPTH)+1  rise+flat time L.
- cfg_m  in  10  unsigned pole-zero multiplier M.
- cfg_shift  in  5  arithmetic right shift applied to output.
- cfg_err  out  1  one-cycle pulse: rejected configuration.
- sat_flag  out  1  sticky: at least one output was clamped.
- out_data  out  OUT_W  signed filtered sample.
- out_valid  out  1  out_data valid this cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0.
  - Delay line, accumulators and warm-up counter cleared.
  - Active configuration = DEF_*.
- Arithmetic:
  - in_data is zero-extended into signed ACC_W.
  - For accepted sample n: d(n) = v(n) - v(n-K) - v(n-L) + v(n-K-L).
  - p(n) = p(n-1) + d(n).
  - r(n) = p(n) + M*d(n).
  - s(n) = s(n-1) + r(n).
  - Output = s(n) >>> SHIFT, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Internal accumulators wrap modulo 2^ACC_W; only the output saturates. A clamp sets sat_flag.
- Pipeline timing:
  - Delay line and accumulators advance only on in_valid.
  - Valid-tagged pipeline of 4 stages: d, p, r/s, output register.
  - out_valid for sample n rises exactly 4 clk after the in_valid cycle of sample n, independent of gaps between samples.
- Warm-up: out_valid is suppressed for the first K+L accepted samples after reset or after an accepted cfg_load. Those samples still update the delay line and accumulators.
- Configuration acceptance:
  - cfg_load is accepted iff 1 <= cfg_k <= cfg_l and cfg_k + cfg_l <= DEPTH.
  - On accept, the next edge:
    - latches the new configuration;
    - clears the delay line, p, s, pipeline valid tags and warm-up counter;
    - clears sat_flag.
  - An in_valid in the same cycle as an accepted cfg_load is dropped.
- Configuration rejection: cfg_err pulses for 1 cycle. Configuration and state are unchanged, and the filter keeps running.
- Reset asserted mid-stream: in-flight samples are discarded and no out_valid is produced for them.

Decomposition:
- Package filter_pkg holds:
  - the ACC_W signed type;
  - the config struct {k, l, m, shift};
  - DEF_* constants;
  - a saturate function.
- Sub-module tap_delay_line:
  - DEPTH x ADC_W shift register with shift enable and synchronous clear;
  - runtime tap outputs at K, L and K+L.

Test Plan:
- Step response:
  - Setup: K=2, L=4, M=0, SHIFT=0.
  - Stimulus: 6 samples of 0, then constant 10.
  - Required: first out_valid on the 7th sample; from the step, out_data = 10, 30, 50, 70, 80, 80, 80..., each 4 clk after its in_valid.
- Gapped input: repeat the step test with in_valid every 3rd cycle → identical out_data sequence, each 4 clk after its in_valid.
- Saturation: OUT_W=16, SHIFT=0, constant 4095 → out_data clamps at 32767 and holds; sat_flag=1 until the next accepted cfg_load.
- Bad configuration: cfg_k=5, cfg_l=3 → cfg_err high 1 cycle; output stream continues unchanged.
- Good configuration mid-stream: cfg_k=3, cfg_l=6 → out_valid low for the next 9 accepted samples; coincident in_valid is dropped.
- Mid-stream reset: assert reset while the pipeline is full → out_valid=0 and out_data=0 immediately. After release, DEF_* config applies and 12 samples of warm-up occur before the first valid output.
